// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB line-state, pattern and rx FSM definitions
package usb_pkg;

  // Line states as {dn,dp}
  typedef enum logic [1:0] {
    USB_LS_SE0 = 2'b00,
    USB_LS_J   = 2'b01,
    USB_LS_K   = 2'b10,
    USB_LS_SE1 = 2'b11
  } usb_line_state_t;

  // Oldest sample in the top bits: K J K J K J K K
  localparam logic [15:0] USB_SYNC_PATTERN = {USB_LS_K, USB_LS_J, USB_LS_K, USB_LS_J,
                                              USB_LS_K, USB_LS_J, USB_LS_K, USB_LS_K};
  localparam logic [5:0]  USB_EOP_PATTERN  = {USB_LS_SE0, USB_LS_SE0, USB_LS_J};
  localparam int          USB_STUFF_BITS_N = 6;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_EOP,
    RX_ERR
  } usb_rx_state_t;

endpackage

// File: rtl/usb_fe_rx_dpll.sv
// rtl/usb_fe_rx_dpll.sv - line synchronizer, phase tracker and sample strobe
module usb_fe_rx_dpll
  import usb_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp_rx,
  input  logic       dn_rx,
  output logic [1:0] line_state,
  output logic       sample_stb
);

  localparam int PW = $clog2(OVERSAMPLE);

  logic [1:0]    meta_q;
  logic [1:0]    sync_q;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // Phase is zero on the first clock the new line state is visible
  always_comb begin
    phase_d = phase_q + PW'(1);
    if (meta_q != sync_q) begin
      phase_d = '0;
    end else if (phase_q == PW'(OVERSAMPLE - 1)) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= USB_LS_J;
      sync_q  <= USB_LS_J;
      phase_q <= '0;
    end else begin
      meta_q  <= {dn_rx, dp_rx};
      sync_q  <= meta_q;
      phase_q <= phase_d;
    end
  end

  assign line_state = sync_q;
  assign sample_stb = (phase_q == PW'(OVERSAMPLE / 2 - 1));

endmodule

// File: rtl/usb_fe_rx.sv
// rtl/usb_fe_rx.sv - USB FS receive front-end: SYNC, NRZI, unstuff, bytes, EOP, bus reset
module usb_fe_rx
  import usb_pkg::*;
#(
  parameter int OVERSAMPLE   = 4,
  parameter int RESET_CYCLES = 120,
  parameter int MAX_SE0_BITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dp_rx,
  input  logic       dn_rx,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       usb_reset
);

  localparam int RCW  = $clog2(RESET_CYCLES + 1);
  localparam int SE0W = $clog2(MAX_SE0_BITS + 2);

  logic          sample_stb;
  logic [1:0]    ls;

  usb_rx_state_t state_q, state_d;
  logic [15:0]   hist_q, hist_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    ones_cnt_q, ones_cnt_d;
  logic [1:0]    prev_q, prev_d;
  logic [SE0W-1:0] se0_cnt_q, se0_cnt_d;
  logic          j_seen_q, j_seen_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;
  logic          active_q, active_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic          nrzi_bit;
  logic          go_err;

  usb_fe_rx_dpll #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_dpll (
    .clk       (clk),
    .rst_n     (rst_n),
    .dp_rx     (dp_rx),
    .dn_rx     (dn_rx),
    .line_state(ls),
    .sample_stb(sample_stb)
  );

  // Bus reset runs on every clock of the synchronized line, not on bit samples
  always_comb begin
    rst_cnt_d = '0;
    if (ls == USB_LS_SE0) begin
      rst_cnt_d = (rst_cnt_q == RCW'(RESET_CYCLES)) ? rst_cnt_q : rst_cnt_q + RCW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    prev_d     = prev_q;
    se0_cnt_d  = se0_cnt_q;
    j_seen_d   = j_seen_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    active_d   = (eop_q || err_q) ? 1'b0 : active_q;
    nrzi_bit   = (ls == prev_q);
    go_err     = 1'b0;

    if (sample_stb) begin
      hist_d = {hist_q[13:0], ls};
    end

    case (state_q)
      RX_IDLE: begin
        if (sample_stb && hist_d == USB_SYNC_PATTERN) begin
          state_d    = RX_DATA;
          active_d   = 1'b1;
          ones_cnt_d = 3'd1;
          bit_cnt_d  = 3'd0;
          prev_d     = USB_LS_K;
        end
      end
      RX_DATA: begin
        if (sample_stb) begin
          case (ls)
            USB_LS_J, USB_LS_K: begin
              prev_d = ls;
              if (ones_cnt_q == 3'(USB_STUFF_BITS_N)) begin
                ones_cnt_d = 3'd0;
                go_err     = nrzi_bit;
              end else begin
                shift_d    = {nrzi_bit, shift_q[7:1]};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                ones_cnt_d = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                if (bit_cnt_q == 3'd7) begin
                  data_d  = shift_d;
                  valid_d = 1'b1;
                end
              end
            end
            USB_LS_SE0: begin
              state_d   = RX_EOP;
              se0_cnt_d = SE0W'(1);
            end
            default: go_err = 1'b1;
          endcase
        end
      end
      RX_EOP: begin
        if (sample_stb) begin
          case (ls)
            USB_LS_SE0: begin
              se0_cnt_d = se0_cnt_q + SE0W'(1);
              go_err    = (se0_cnt_q >= SE0W'(MAX_SE0_BITS));
            end
            USB_LS_J: begin
              eop_d   = (bit_cnt_q == 3'd0);
              err_d   = (bit_cnt_q != 3'd0);
              state_d = RX_IDLE;
            end
            default: go_err = 1'b1;
          endcase
        end
      end
      default: begin
        if (sample_stb) begin
          if (ls == USB_LS_J) begin
            j_seen_d = 1'b1;
            if (j_seen_q) begin
              state_d  = RX_IDLE;
              hist_d   = {8{USB_LS_J}};
              j_seen_d = 1'b0;
            end
          end else begin
            j_seen_d = 1'b0;
          end
        end
      end
    endcase

    if (usb_reset && (state_q == RX_DATA || state_q == RX_EOP)) begin
      go_err = 1'b1;
    end

    if (go_err) begin
      state_d  = RX_ERR;
      err_d    = 1'b1;
      j_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      hist_q     <= {8{USB_LS_J}};
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      prev_q     <= USB_LS_J;
      se0_cnt_q  <= '0;
      j_seen_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
      active_q   <= 1'b0;
      rst_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      prev_q     <= prev_d;
      se0_cnt_q  <= se0_cnt_d;
      j_seen_q   <= j_seen_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
      active_q   <= active_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

  assign line_state = ls;
  assign rx_active  = active_q;
  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_eop     = eop_q;
  assign rx_err     = err_q;
  assign usb_reset  = (rst_cnt_q == RCW'(RESET_CYCLES));

endmodule
